// File: rtl/pixel_pkg.sv
// Shared definitions for the LCD-to-LED pixel line buffer controller.
// Holds the FSM state encodings and the default bus widths.
package pixel_pkg;

    localparam int PIXEL_DATA_WIDTH = 24;
    localparam int PIXEL_ADDR_WIDTH = 9;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_FILL = 1'b1
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_LAST = 2'd2
    } rd_state_t;

endpackage

// File: rtl/pixel_line_ctrl.sv
// Ping-pong line buffer: LCD pixels fill one RAM bank while the LED side drains the other.
// LED pixels appear 2 cycles after an accepted line request; full lines on the LCD side are dropped (sticky overflow).
module pixel_line_ctrl
    import pixel_pkg::*;
#(
    parameter int DATA_WIDTH  = PIXEL_DATA_WIDTH,
    parameter int ADDR_WIDTH  = PIXEL_ADDR_WIDTH,
    parameter int LINE_PIXELS = 256
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  lcd_line_start,
    input  logic                  lcd_pixel_valid,
    input  logic [DATA_WIDTH-1:0] lcd_pixel_data,
    input  logic                  led_line_req,
    output logic                  led_pixel_valid,
    output logic [DATA_WIDTH-1:0] led_pixel_data,
    output logic                  led_line_done,
    output logic                  led_underrun,
    output logic                  overflow,
    output logic [ADDR_WIDTH-1:0] ram_addr_a,
    output logic [DATA_WIDTH-1:0] ram_data_a,
    output logic                  ram_we_a,
    output logic [ADDR_WIDTH-1:0] ram_addr_b,
    input  logic [DATA_WIDTH-1:0] ram_q_b
);

    localparam int            IW       = ADDR_WIDTH - 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LINE_PIXELS - 1);

    logic [1:0]    full, full_nxt;
    logic          wb, rb;

    wr_state_t     wr_state, wr_state_nxt;
    logic [IW-1:0] wr_idx, wr_idx_nxt, wr_idx_eff;
    logic          wr_en;
    logic          fill_done;
    logic          overflow_set;

    rd_state_t     rd_state, rd_state_nxt;
    logic [IW-1:0] rd_idx, rd_idx_nxt;
    logic          rd_issue;
    logic          rd_release;
    logic          underrun_set;

    logic          pix_vld_q;
    logic          underrun_q;
    logic          overflow_q;

    // Write side: a line start while filling restarts the same bank at index 0.
    always_comb begin
        wr_state_nxt = wr_state;
        wr_idx_nxt   = wr_idx;
        wr_idx_eff   = wr_idx;
        wr_en        = 1'b0;
        fill_done    = 1'b0;
        overflow_set = 1'b0;
        case (wr_state)
            W_IDLE: begin
                if (lcd_line_start) begin
                    if (full[wb]) begin
                        overflow_set = 1'b1;
                    end else begin
                        wr_state_nxt = W_FILL;
                        wr_idx_nxt   = '0;
                    end
                end
            end
            W_FILL: begin
                if (lcd_line_start) begin
                    wr_idx_eff = '0;
                    wr_idx_nxt = '0;
                end
                if (lcd_pixel_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_eff == LAST_IDX) begin
                        fill_done    = 1'b1;
                        wr_state_nxt = W_IDLE;
                        wr_idx_nxt   = '0;
                    end else begin
                        wr_idx_nxt = wr_idx_eff + IW'(1);
                    end
                end
            end
            default: begin
                wr_state_nxt = W_IDLE;
                wr_idx_nxt   = '0;
            end
        endcase
    end

    // Read side: R_LAST is the cycle in which the final pixel leaves the RAM.
    always_comb begin
        rd_state_nxt = rd_state;
        rd_idx_nxt   = rd_idx;
        rd_issue     = 1'b0;
        rd_release   = 1'b0;
        underrun_set = 1'b0;
        case (rd_state)
            R_IDLE: begin
                if (led_line_req) begin
                    if (full[rb]) begin
                        rd_state_nxt = R_READ;
                        rd_idx_nxt   = '0;
                    end else begin
                        underrun_set = 1'b1;
                    end
                end
            end
            R_READ: begin
                rd_issue = 1'b1;
                if (rd_idx == LAST_IDX) begin
                    rd_state_nxt = R_LAST;
                    rd_idx_nxt   = '0;
                end else begin
                    rd_idx_nxt = rd_idx + IW'(1);
                end
            end
            R_LAST: begin
                rd_release   = 1'b1;
                rd_state_nxt = R_IDLE;
            end
            default: begin
                rd_state_nxt = R_IDLE;
                rd_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        full_nxt = full;
        if (fill_done) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_release) begin
            full_nxt[rb] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_state   <= W_IDLE;
            rd_state   <= R_IDLE;
            wr_idx     <= '0;
            rd_idx     <= '0;
            full       <= '0;
            wb         <= 1'b0;
            rb         <= 1'b0;
            pix_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_state   <= wr_state_nxt;
            rd_state   <= rd_state_nxt;
            wr_idx     <= wr_idx_nxt;
            rd_idx     <= rd_idx_nxt;
            full       <= full_nxt;
            wb         <= wb ^ fill_done;
            rb         <= rb ^ rd_release;
            pix_vld_q  <= rd_issue;
            underrun_q <= underrun_set;
            overflow_q <= overflow_q | overflow_set;
        end
    end

    // The RAM's own output register is the pipeline stage, so read data is gated by the delayed issue flag.
    assign ram_we_a        = wr_en;
    assign ram_addr_a      = wr_en ? {wb, wr_idx_eff} : '0;
    assign ram_data_a      = wr_en ? lcd_pixel_data : '0;
    assign ram_addr_b      = rd_issue ? {rb, rd_idx} : '0;
    assign led_pixel_valid = pix_vld_q;
    assign led_pixel_data  = pix_vld_q ? ram_q_b : '0;
    assign led_line_done   = (rd_state == R_LAST);
    assign led_underrun    = underrun_q;
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_pixel_line_ctrl.sv
// Bench for pixel_line_ctrl with LINE_PIXELS=4: vector table, directed corner sequences,
// then random traffic against a line-queue reference model.
module tb_pixel_line_ctrl;

    localparam int DW = 24;
    localparam int AW = 9;
    localparam int LP = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          lcd_line_start = 1'b0;
    logic          lcd_pixel_valid = 1'b0;
    logic [DW-1:0] lcd_pixel_data = '0;
    logic          led_line_req = 1'b0;
    logic          led_pixel_valid;
    logic [DW-1:0] led_pixel_data;
    logic          led_line_done;
    logic          led_underrun;
    logic          overflow;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_data_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_q_b = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    pixel_line_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LINE_PIXELS(LP)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .lcd_line_start (lcd_line_start),
        .lcd_pixel_valid(lcd_pixel_valid),
        .lcd_pixel_data (lcd_pixel_data),
        .led_line_req   (led_line_req),
        .led_pixel_valid(led_pixel_valid),
        .led_pixel_data (led_pixel_data),
        .led_line_done  (led_line_done),
        .led_underrun   (led_underrun),
        .overflow       (overflow),
        .ram_addr_a     (ram_addr_a),
        .ram_data_a     (ram_data_a),
        .ram_we_a       (ram_we_a),
        .ram_addr_b     (ram_addr_b),
        .ram_q_b        (ram_q_b)
    );

    always #5 clk = ~clk;

    // Dual-port RAM, one cycle read latency.
    always @(posedge clk) begin
        if (ram_we_a) mem[ram_addr_a] <= ram_data_a;
        ram_q_b <= mem[ram_addr_b];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit st, input bit vl, input logic [DW-1:0] d, input bit rq);
        @(posedge clk);
        #1;
        lcd_line_start  = st;
        lcd_pixel_valid = vl;
        lcd_pixel_data  = d;
        led_line_req    = rq;
        @(negedge clk);
    endtask

    // Reference model: buffered lines as a flat pixel queue (LP pixels per line).
    logic [DW-1:0] px_q[$];
    logic [DW-1:0] m_buf [LP];
    bit m_fill, m_wb, m_rb, m_ov, m_urp;
    int m_n, m_p;

    task automatic model_reset();
        px_q.delete();
        m_fill = 0; m_wb = 0; m_rb = 0; m_ov = 0; m_urp = 0;
        m_n = 0; m_p = 0;
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        lcd_line_start  = 1'b0;
        lcd_pixel_valid = 1'b0;
        lcd_pixel_data  = '0;
        led_line_req    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", 32'(ram_we_a), 0);
        chk("rst_addr_a", 32'(ram_addr_a), 0);
        chk("rst_data_a", 32'(ram_data_a), 0);
        chk("rst_addr_b", 32'(ram_addr_b), 0);
        chk("rst_vld", 32'(led_pixel_valid), 0);
        chk("rst_pix", 32'(led_pixel_data), 0);
        chk("rst_done", 32'(led_line_done), 0);
        chk("rst_underrun", 32'(led_underrun), 0);
        chk("rst_overflow", 32'(overflow), 0);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One random cycle checked against the model, then the model advances.
    task automatic rcycle(input bit st, input bit vl, input logic [DW-1:0] d, input bit rq);
        int  cnt, ne, e_aa, e_ab;
        bit  e_we, e_v, push, n_fill;
        logic [DW-1:0] e_pd;
        drive(st, vl, d, rq);
        cnt    = px_q.size() / LP;
        e_we   = 0; e_aa = 0; push = 0;
        n_fill = m_fill;
        ne     = m_n;
        if (!m_fill) begin
            if (st) begin
                if (cnt == 2) m_ov = m_ov;
                else begin n_fill = 1; ne = 0; end
            end
        end else begin
            ne = st ? 0 : m_n;
            if (vl) begin
                e_we = 1;
                e_aa = int'(m_wb) * 256 + ne;
                m_buf[ne] = d;
                if (ne == LP - 1) begin push = 1; n_fill = 0; ne = 0; end
                else ne = ne + 1;
            end
        end
        e_ab = (m_p >= 1 && m_p <= LP) ? int'(m_rb) * 256 + (m_p - 1) : 0;
        e_v  = (m_p >= 2 && m_p <= LP + 1);
        e_pd = e_v ? px_q[m_p-2] : '0;

        chk("r_we", 32'(ram_we_a), 32'(e_we));
        if (e_we) begin
            chk("r_addr_a", 32'(ram_addr_a), 32'(e_aa));
            chk("r_data_a", 32'(ram_data_a), 32'(d));
        end
        if (m_p >= 1 && m_p <= LP) chk("r_addr_b", 32'(ram_addr_b), 32'(e_ab));
        chk("r_vld", 32'(led_pixel_valid), 32'(e_v));
        if (e_v) chk("r_pix", 32'(led_pixel_data), 32'(e_pd));
        chk("r_done", 32'(led_line_done), 32'(m_p == LP + 1));
        chk("r_underrun", 32'(led_underrun), 32'(m_urp));
        chk("r_overflow", 32'(overflow), 32'(m_ov));

        if (!m_fill && st && cnt == 2) m_ov = 1;
        m_urp = 0;
        if (m_p == 0) begin
            if (rq) begin
                if (cnt > 0) m_p = 1;
                else m_urp = 1;
            end
        end else if (m_p == LP + 1) begin
            repeat (LP) void'(px_q.pop_front());
            m_rb = ~m_rb;
            m_p  = 0;
        end else begin
            m_p = m_p + 1;
        end
        if (push) begin
            for (int i = 0; i < LP; i++) px_q.push_back(m_buf[i]);
            m_wb = ~m_wb;
        end
        m_fill = n_fill;
        m_n    = ne;
    endtask

    // Line start then LP pixels base..base+3; bank<0 means the line must not be written.
    task automatic send_line(input logic [DW-1:0] base, input int bank);
        drive(1, 0, '0, 0);
        chk("line_start_we", 32'(ram_we_a), 0);
        for (int i = 0; i < LP; i++) begin
            drive(0, 1, base + DW'(i), 0);
            if (bank < 0) begin
                chk("drop_we", 32'(ram_we_a), 0);
            end else begin
                chk("line_we", 32'(ram_we_a), 1);
                chk("line_addr_a", 32'(ram_addr_a), 32'(bank * 256 + i));
                chk("line_data_a", 32'(ram_data_a), 32'(base + DW'(i)));
            end
        end
    endtask

    task automatic read_line(input logic [DW-1:0] base, input int bank);
        drive(0, 0, '0, 1);
        chk("rd_req_vld", 32'(led_pixel_valid), 0);
        for (int k = 1; k <= LP + 1; k++) begin
            drive(0, 0, '0, 0);
            if (k <= LP) chk("rd_addr_b", 32'(ram_addr_b), 32'(bank * 256 + k - 1));
            chk("rd_vld", 32'(led_pixel_valid), 32'(k >= 2));
            if (k >= 2) chk("rd_pix", 32'(led_pixel_data), 32'(base + DW'(k - 2)));
            chk("rd_done", 32'(led_line_done), 32'(k == LP + 1));
        end
        drive(0, 0, '0, 0);
        chk("rd_after_vld", 32'(led_pixel_valid), 0);
        chk("rd_after_underrun", 32'(led_underrun), 0);
    endtask

    typedef struct {
        bit st; bit vl; logic [DW-1:0] d; bit rq;
        bit we; int aa; logic [DW-1:0] da; int ab;
        bit v; logic [DW-1:0] pd; bit done; bit ur; bit ov;
    } vec_t;
    vec_t vecs[$];

    task automatic addv(input bit st, vl, input logic [DW-1:0] d, input bit rq,
                        input bit we, input int aa, input logic [DW-1:0] da, input int ab,
                        input bit v, input logic [DW-1:0] pd, input bit done, ur, ov);
        vec_t x;
        x.st = st; x.vl = vl; x.d = d; x.rq = rq; x.we = we; x.aa = aa; x.da = da;
        x.ab = ab; x.v = v; x.pd = pd; x.done = done; x.ur = ur; x.ov = ov;
        vecs.push_back(x);
    endtask

    initial begin
        //   st vl d      rq  we aa   da     ab   v  pd     dn ur ov
        addv(1, 0, 0,     0,  0, 0,   0,     -1,  0, 0,     0, 0, 0);
        addv(0, 1, 'h10,  0,  1, 0,   'h10,  -1,  0, 0,     0, 0, 0);
        addv(0, 1, 'h11,  0,  1, 1,   'h11,  -1,  0, 0,     0, 0, 0);
        addv(0, 1, 'h12,  0,  1, 2,   'h12,  -1,  0, 0,     0, 0, 0);
        addv(0, 1, 'h13,  0,  1, 3,   'h13,  -1,  0, 0,     0, 0, 0);
        addv(0, 0, 0,     1,  0, 0,   0,     -1,  0, 0,     0, 0, 0);
        addv(0, 0, 0,     0,  0, 0,   0,     0,   0, 0,     0, 0, 0);
        addv(0, 0, 0,     0,  0, 0,   0,     1,   1, 'h10,  0, 0, 0);
        addv(0, 0, 0,     1,  0, 0,   0,     2,   1, 'h11,  0, 0, 0);
        addv(0, 0, 0,     0,  0, 0,   0,     3,   1, 'h12,  0, 0, 0);
        addv(0, 0, 0,     0,  0, 0,   0,     -1,  1, 'h13,  1, 0, 0);
        addv(0, 0, 0,     1,  0, 0,   0,     -1,  0, 0,     0, 0, 0);
        addv(0, 0, 0,     0,  0, 0,   0,     -1,  0, 0,     0, 1, 0);
        addv(0, 1, 'h55,  0,  0, 0,   0,     -1,  0, 0,     0, 0, 0);
        addv(1, 0, 0,     0,  0, 0,   0,     -1,  0, 0,     0, 0, 0);
        addv(0, 1, 'h20,  0,  1, 256, 'h20,  -1,  0, 0,     0, 0, 0);

        do_reset();
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].vl, vecs[i].d, vecs[i].rq);
            chk($sformatf("vec%0d_we", i), 32'(ram_we_a), 32'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr_a", i), 32'(ram_addr_a), 32'(vecs[i].aa));
                chk($sformatf("vec%0d_data_a", i), 32'(ram_data_a), 32'(vecs[i].da));
            end
            if (vecs[i].ab >= 0) chk($sformatf("vec%0d_addr_b", i), 32'(ram_addr_b), 32'(vecs[i].ab));
            chk($sformatf("vec%0d_vld", i), 32'(led_pixel_valid), 32'(vecs[i].v));
            if (vecs[i].v) chk($sformatf("vec%0d_pix", i), 32'(led_pixel_data), 32'(vecs[i].pd));
            chk($sformatf("vec%0d_done", i), 32'(led_line_done), 32'(vecs[i].done));
            chk($sformatf("vec%0d_underrun", i), 32'(led_underrun), 32'(vecs[i].ur));
            chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].ov));
        end

        // Both banks full: third line dropped, overflow sticks; buffered lines intact.
        do_reset();
        send_line('h100, 0);
        send_line('h200, 1);
        chk("ovf_before", 32'(overflow), 0);
        send_line('h300, -1);
        chk("ovf_set", 32'(overflow), 1);
        repeat (5) drive(0, 0, '0, 0);
        chk("ovf_sticky", 32'(overflow), 1);
        read_line('h100, 0);
        read_line('h200, 1);
        chk("ovf_after_reads", 32'(overflow), 1);

        // Abandoned partial lines, including a restart with a pixel in the same cycle.
        do_reset();
        drive(1, 0, '0, 0);
        drive(0, 1, 'h55, 0);
        drive(0, 1, 'h56, 0);
        chk("partial_addr", 32'(ram_addr_a), 1);
        send_line('hA0, 0);
        drive(1, 0, '0, 0);
        drive(0, 1, 'hC0, 0);
        drive(1, 1, 'hB0, 0);
        chk("restart_we", 32'(ram_we_a), 1);
        chk("restart_addr", 32'(ram_addr_a), 256);
        chk("restart_data", 32'(ram_data_a), 'hB0);
        for (int i = 1; i < LP; i++) drive(0, 1, 'hB0 + DW'(i), 0);
        read_line('hA0, 0);
        read_line('hB0, 1);

        // Reset in the middle of a read drops everything; next line lands in bank 0.
        do_reset();
        send_line('h40, 0);
        send_line('h50, 1);
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        drive(0, 0, '0, 0);
        chk("pre_rst_vld", 32'(led_pixel_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_vld", 32'(led_pixel_valid), 0);
        chk("async_rst_pix", 32'(led_pixel_data), 0);
        chk("async_rst_addr_b", 32'(ram_addr_b), 0);
        chk("async_rst_done", 32'(led_line_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0, 0, '0, 1);
        drive(0, 0, '0, 0);
        chk("post_rst_underrun", 32'(led_underrun), 1);
        chk("post_rst_vld", 32'(led_pixel_valid), 0);
        send_line('h60, 0);
        read_line('h60, 0);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            rcycle($urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
                   DW'($urandom), $urandom_range(0, 11) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
